// File: rtl/pc_fetch_unit.sv
// Fetch program counter with variable-width advance, prioritised redirects
// and a circular return-address stack for call/return prediction.
module pc_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter int              FETCH_WIDTH  = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int              RAS_DEPTH    = 8,
  localparam int             CW           = $clog2(FETCH_WIDTH + 1),
  localparam int             RW           = $clog2(RAS_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CW-1:0]   advance,
  input  logic            stall,
  input  logic            rob_jmp_write,
  input  logic [XLEN-1:0] rob_jmp_address,
  input  logic            pred_jmp_write,
  input  logic [XLEN-1:0] pred_jmp_address,
  input  logic            ras_push,
  input  logic [XLEN-1:0] ras_push_address,
  input  logic            ras_pop,
  input  logic            ras_flush,
  output logic [XLEN-1:0] address,
  output logic            addr_misaligned,
  output logic [XLEN-1:0] ras_top,
  output logic            ras_empty,
  output logic [RW:0]     ras_count
);

  // No handshake: every request input is a single-cycle event sampled at the
  // rising edge; holding one high for N cycles produces N separate events.

  localparam logic [CW-1:0] FW_C     = CW'(FETCH_WIDTH);
  localparam logic [RW-1:0] TP_ONE   = RW'(1);
  localparam logic [RW:0]   CNT_ONE  = (RW + 1)'(1);
  localparam logic [RW:0]   CNT_FULL = (RW + 1)'(RAS_DEPTH);

  // ---------------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] pc_q, pc_d;
  logic            mis_q, mis_d;
  logic [CW-1:0]   adv_sat;
  logic [XLEN-1:0] pc_step;

  always_comb begin
    adv_sat = (advance > FW_C) ? FW_C : advance;
    pc_step = {{(XLEN - CW - 2){1'b0}}, adv_sat, 2'b00};
  end

  // ROB redirect outranks the predicted jump; either one outranks stall.
  always_comb begin
    pc_d  = pc_q;
    mis_d = mis_q;
    if (rob_jmp_write) begin
      pc_d  = {rob_jmp_address[XLEN-1:2], 2'b00};
      mis_d = |rob_jmp_address[1:0];
    end else if (pred_jmp_write) begin
      pc_d  = {pred_jmp_address[XLEN-1:2], 2'b00};
      mis_d = |pred_jmp_address[1:0];
    end else if (!stall) begin
      pc_d  = pc_q + pc_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RESET_VECTOR;
      mis_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      mis_q <= mis_d;
    end
  end

  assign address         = pc_q;
  assign addr_misaligned = mis_q;

  // ---------------------------------------------------------------------------
  // Return-address stack
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] ras_mem [RAS_DEPTH];
  logic [RW-1:0]   tp_q, tp_d;
  logic [RW:0]     cnt_q, cnt_d;
  logic            ras_we;
  logic [RW-1:0]   ras_widx;
  logic            has_entries;

  assign has_entries = (cnt_q != '0);

  // A push paired with a pop on a non-empty stack replaces the top in place.
  always_comb begin
    tp_d     = tp_q;
    cnt_d    = cnt_q;
    ras_we   = 1'b0;
    ras_widx = tp_q + TP_ONE;
    if (ras_flush) begin
      tp_d  = '0;
      cnt_d = '0;
    end else if (ras_push && ras_pop && has_entries) begin
      ras_we   = 1'b1;
      ras_widx = tp_q;
    end else if (ras_push) begin
      ras_we = 1'b1;
      tp_d   = tp_q + TP_ONE;
      cnt_d  = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_ONE;
    end else if (ras_pop && has_entries) begin
      tp_d  = tp_q - TP_ONE;
      cnt_d = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tp_q  <= '0;
      cnt_q <= '0;
    end else begin
      tp_q  <= tp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage carries no reset; cnt alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (ras_we) begin
      ras_mem[ras_widx] <= ras_push_address;
    end
  end

  assign ras_empty = !has_entries;
  assign ras_count = cnt_q;
  assign ras_top   = has_entries ? ras_mem[tp_q] : '0;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: PC stepping, redirect priority,
// misalignment flag, wrap-around, saturation and RAS behaviour.
module tb_pc_fetch_unit;

  localparam int XLEN = 32;
  localparam int FW   = 2;
  localparam int RD   = 8;
  localparam int CW   = $clog2(FW + 1);
  localparam int RW   = $clog2(RD);

  logic            clk = 1'b0;
  logic            reset;
  logic [CW-1:0]   advance;
  logic            stall;
  logic            rob_jmp_write;
  logic [XLEN-1:0] rob_jmp_address;
  logic            pred_jmp_write;
  logic [XLEN-1:0] pred_jmp_address;
  logic            ras_push;
  logic [XLEN-1:0] ras_push_address;
  logic            ras_pop;
  logic            ras_flush;
  logic [XLEN-1:0] address;
  logic            addr_misaligned;
  logic [XLEN-1:0] ras_top;
  logic            ras_empty;
  logic [RW:0]     ras_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [XLEN-1:0] a [1:9];

  pc_fetch_unit #(
    .XLEN(XLEN), .FETCH_WIDTH(FW), .RESET_VECTOR(32'h0000_1000), .RAS_DEPTH(RD)
  ) dut (
    .clk(clk), .reset(reset), .advance(advance), .stall(stall),
    .rob_jmp_write(rob_jmp_write), .rob_jmp_address(rob_jmp_address),
    .pred_jmp_write(pred_jmp_write), .pred_jmp_address(pred_jmp_address),
    .ras_push(ras_push), .ras_push_address(ras_push_address),
    .ras_pop(ras_pop), .ras_flush(ras_flush),
    .address(address), .addr_misaligned(addr_misaligned),
    .ras_top(ras_top), .ras_empty(ras_empty), .ras_count(ras_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    advance = '0; stall = 1'b0;
    rob_jmp_write = 1'b0; rob_jmp_address = '0;
    pred_jmp_write = 1'b0; pred_jmp_address = '0;
    ras_push = 1'b0; ras_push_address = '0; ras_pop = 1'b0; ras_flush = 1'b0;
  endtask

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic drive_adv(input int n);
    advance = CW'(n);
    step();
  endtask

  task automatic drive_rob(input logic [31:0] t);
    rob_jmp_write = 1'b1; rob_jmp_address = t;
    step();
  endtask

  task automatic drive_pred(input logic [31:0] t);
    pred_jmp_write = 1'b1; pred_jmp_address = t;
    step();
  endtask

  task automatic drive_ras(input logic push, input logic pop, input logic flush,
                           input logic [31:0] val);
    ras_push = push; ras_pop = pop; ras_flush = flush; ras_push_address = val;
    step();
  endtask

  task automatic check_ras(input string tag, input logic [31:0] top, input int cnt);
    check({tag, "_top"}, ras_top, top);
    check({tag, "_cnt"}, 32'(ras_count), 32'(cnt));
    check({tag, "_empty"}, 32'(ras_empty), (cnt == 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    for (int i = 1; i <= 9; i++) a[i] = 32'h8000_0000 + 32'(i * 16);
    idle();
    reset = 1'b1;
    #1;
    check("rst_addr", address, 32'h1000);
    check("rst_mis", 32'(addr_misaligned), 32'd0);
    check_ras("rst", 32'h0, 0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    check("rst_hold", address, 32'h1000);

    // advance by 2 for three cycles
    drive_adv(2); check("adv_1", address, 32'h1008);
    drive_adv(2); check("adv_2", address, 32'h1010);
    drive_adv(2); check("adv_3", address, 32'h1018);

    // predicted jump back to 0x1010, then full-priority collision there
    drive_pred(32'h1010); check("pred_1010", address, 32'h1010);
    rob_jmp_write = 1'b1; rob_jmp_address = 32'h2000;
    pred_jmp_write = 1'b1; pred_jmp_address = 32'h3000;
    advance = 2'd2; stall = 1'b1;
    step();
    check("prio_addr", address, 32'h2000);
    check("prio_mis", 32'(addr_misaligned), 32'd0);

    advance = 2'd2; stall = 1'b1; step(); check("stall", address, 32'h2000);
    drive_adv(0); check("adv0", address, 32'h2000);
    pred_jmp_write = 1'b1; pred_jmp_address = 32'h5000; stall = 1'b1;
    step(); check("pred_over_stall", address, 32'h5000);

    // misalignment flag
    drive_pred(32'h4006);
    check("mis_addr", address, 32'h4004);
    check("mis_set", 32'(addr_misaligned), 32'd1);
    drive_adv(1);
    check("mis_adv_addr", address, 32'h4008);
    check("mis_sticky", 32'(addr_misaligned), 32'd1);
    stall = 1'b1; step();
    check("mis_stall", 32'(addr_misaligned), 32'd1);
    drive_rob(32'h6000);
    check("mis_clr_addr", address, 32'h6000);
    check("mis_clr", 32'(addr_misaligned), 32'd0);
    drive_rob(32'h7003);
    check("rob_mis_addr", address, 32'h7000);
    check("rob_mis", 32'(addr_misaligned), 32'd1);

    // wrap-around and saturation
    drive_rob(32'hFFFF_FFFC);
    drive_adv(2); check("wrap", address, 32'h0000_0004);
    drive_adv(3); check("sat", address, 32'h0000_000C);

    // RAS overflow
    for (int i = 1; i <= 9; i++) drive_ras(1'b1, 1'b0, 1'b0, a[i]);
    check_ras("ovf", a[9], 8);
    for (int i = 9; i >= 2; i--) begin
      check("pop_top", ras_top, a[i]);
      drive_ras(1'b0, 1'b1, 1'b0, 32'h0);
    end
    check_ras("drained", 32'h0, 0);
    drive_ras(1'b0, 1'b1, 1'b0, 32'h0);
    check_ras("pop_empty", 32'h0, 0);

    // push+pop replace, flush override
    drive_ras(1'b1, 1'b0, 1'b0, a[1]);
    drive_ras(1'b1, 1'b0, 1'b0, a[2]);
    check_ras("two", a[2], 2);
    drive_ras(1'b1, 1'b1, 1'b0, 32'hB0B0_0000);
    check_ras("replace", 32'hB0B0_0000, 2);
    drive_ras(1'b0, 1'b1, 1'b0, 32'h0);
    check_ras("under_replace", a[1], 1);
    drive_ras(1'b1, 1'b0, 1'b0, 32'hC0C0_0000);
    check_ras("re_push", 32'hC0C0_0000, 2);
    drive_ras(1'b1, 1'b0, 1'b1, 32'hDEAD_0000);
    check_ras("flush", 32'h0, 0);
    drive_ras(1'b1, 1'b1, 1'b0, 32'hD000_0000);
    check_ras("pushpop_empty", 32'hD000_0000, 1);

    // asynchronous reset mid-stream
    drive_pred(32'h9001);
    check("pre_rst_mis", 32'(addr_misaligned), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_addr", address, 32'h1000);
    check("arst_mis", 32'(addr_misaligned), 32'd0);
    check_ras("arst", 32'h0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    drive_adv(1); check("post_rst_adv", address, 32'h1004);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
